card_shoe: RTL and testbench

//  Upstream card source for the blackjack game FSM. Holds a shoe of NUM_DECKS
//  52-card decks and deals one card per valid/ready handshake without replacement.

---
 rtl/card_pkg.sv | 25 ++
 rtl/card_lfsr.sv | 15 +
 rtl/card_shoe.sv | 150 +++++++++++++++
 tb/tb_card_shoe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared types and constants for the card shoe: FSM states, rank encodings,
// deck size and the rank-to-points mapping.
package card_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    PRESENT,
    SHUFFLE
  } shoe_state_t;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned NUM_RANKS = 13;

  localparam logic [3:0] RANK_ACE   = 4'd1;
  localparam logic [3:0] RANK_JACK  = 4'd11;
  localparam logic [3:0] RANK_QUEEN = 4'd12;
  localparam logic [3:0] RANK_KING  = 4'd13;

  // Face cards score 10, everything else scores its rank (ace counted low).
  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    return (rank >= RANK_JACK) ? 4'd10 : rank;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (maximal length).
// Loads seed on reset and advances on every clock.
module card_lfsr (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= seed;
    else          q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : '0);
  end

endmodule

// File: rtl/card_shoe.sv
// Multi-deck card shoe dealing ranks without replacement over a valid/ack handshake.
// Define CARD_SHOE_TEST_SEQ_EN to replace the random draw with a fixed rank sequence.
module card_shoe
  import card_pkg::*;
#(
  parameter int unsigned NUM_DECKS    = 1,
  parameter int unsigned RESHUFFLE_AT = 12,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int unsigned CW          = $clog2(52 * NUM_DECKS + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          draw_req,
  output logic          ready,
  output logic          card_valid,
  input  logic          card_ack,
  output logic [3:0]    card_rank,
  output logic [3:0]    card_value,
  input  logic          shuffle,
  output logic          shuffling,
  output logic [CW-1:0] cards_left
);

  localparam logic [CW-1:0] FULL_SHOE = CW'(DECK_SIZE * NUM_DECKS);
  localparam logic [4:0]    FULL_RANK = 5'(4 * NUM_DECKS);

  shoe_state_t state;
  logic [4:0]  counts [NUM_RANKS];
  logic        pending;
  logic [3:0]  cand;
  logic        hit;
  logic        low_water;

`ifdef CARD_SHOE_TEST_SEQ_EN
  logic [3:0] seq_idx;

  function automatic logic [3:0] seq_rank(input logic [3:0] i);
    case (i)
      4'd0:    return RANK_ACE;
      4'd1:    return RANK_ACE;
      4'd2:    return 4'd8;
      4'd3:    return 4'd8;
      4'd4:    return RANK_KING;
      4'd5:    return 4'd5;
      4'd6:    return 4'd10;
      4'd7:    return RANK_ACE;
      4'd8:    return 4'd2;
      4'd9:    return 4'd3;
      4'd10:   return 4'd4;
      4'd11:   return 4'd6;
      4'd12:   return 4'd7;
      4'd13:   return 4'd9;
      4'd14:   return RANK_JACK;
      default: return RANK_QUEEN;
    endcase
  endfunction

  assign cand = seq_rank(seq_idx) - 4'd1;
`else
  logic [15:0] lfsr_q;
  logic        lfsr_hi_unused;

  card_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (LFSR_SEED),
    .q       (lfsr_q)
  );

  // Only the low nibble picks a rank slot; values 13..15 simply miss.
  assign cand           = lfsr_q[3:0];
  assign lfsr_hi_unused = ^lfsr_q[15:4];
`endif

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_RANKS; i++)
      if (cand == 4'(i) && counts[i] != '0) hit = 1'b1;
  end

  assign low_water = 32'(cards_left) < RESHUFFLE_AT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ready      <= 1'b1;
      card_valid <= 1'b0;
      card_rank  <= '0;
      card_value <= '0;
      shuffling  <= 1'b0;
      cards_left <= FULL_SHOE;
      pending    <= 1'b0;
      for (int unsigned i = 0; i < NUM_RANKS; i++) counts[i] <= FULL_RANK;
`ifdef CARD_SHOE_TEST_SEQ_EN
      seq_idx    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Refill takes precedence; a draw_req in the same cycle is dropped.
          if (shuffle || pending || low_water) begin
            state     <= SHUFFLE;
            ready     <= 1'b0;
            shuffling <= 1'b1;
          end else if (draw_req) begin
            state <= SEARCH;
            ready <= 1'b0;
          end
        end
        SEARCH: begin
`ifdef CARD_SHOE_TEST_SEQ_EN
          seq_idx <= seq_idx + 4'd1;
`endif
          if (hit) begin
            for (int unsigned i = 0; i < NUM_RANKS; i++)
              if (cand == 4'(i)) counts[i] <= counts[i] - 5'd1;
            cards_left <= cards_left - CW'(1);
            card_rank  <= cand + 4'd1;
            card_value <= rank_to_value(cand + 4'd1);
            card_valid <= 1'b1;
            state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (shuffle) pending <= 1'b1;
          if (card_ack) begin
            card_valid <= 1'b0;
            card_rank  <= '0;
            card_value <= '0;
            ready      <= 1'b1;
            state      <= IDLE;
          end
        end
        SHUFFLE: begin
          for (int unsigned i = 0; i < NUM_RANKS; i++) counts[i] <= FULL_RANK;
          cards_left <= FULL_SHOE;
          pending    <= 1'b0;
          shuffling  <= 1'b0;
          ready      <= 1'b1;
          state      <= IDLE;
`ifdef CARD_SHOE_TEST_SEQ_EN
          seq_idx    <= '0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: expected ranks and search latencies come from
// a shoe model (LFSR or fixed sequence, following CARD_SHOE_TEST_SEQ_EN).
module tb_card_shoe;

  localparam int unsigned ND   = 1;
  localparam int unsigned RA   = 1;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int unsigned CW   = $clog2(52 * ND + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          draw_req = 1'b0;
  logic          card_ack = 1'b0;
  logic          shuffle = 1'b0;
  logic          ready;
  logic          card_valid;
  logic          shuffling;
  logic [3:0]    card_rank;
  logic [3:0]    card_value;
  logic [CW-1:0] cards_left;

  card_shoe #(
    .NUM_DECKS    (ND),
    .RESHUFFLE_AT (RA),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .draw_req   (draw_req),
    .ready      (ready),
    .card_valid (card_valid),
    .card_ack   (card_ack),
    .card_rank  (card_rank),
    .card_value (card_value),
    .shuffle    (shuffle),
    .shuffling  (shuffling),
    .cards_left (cards_left)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) m_lfsr <= SEED;
    else          m_lfsr <= lfsr_step(m_lfsr);

  typedef struct {
    int rank;
    int lat;
  } exp_t;

  exp_t q[$];
  int   m_cnt [13];
  int   m_left;
  int   m_idx;
  int   seq_tbl [16] = '{1, 1, 8, 8, 13, 5, 10, 1, 2, 3, 4, 6, 7, 9, 11, 12};

  task automatic model_full();
    for (int i = 0; i < 13; i++) m_cnt[i] = 4 * ND;
    m_left = 52 * ND;
    m_idx  = 0;
  endtask

  // Called #1 after the accepting edge: m_lfsr then holds the value seen in the
  // first SEARCH cycle. Card appears k+1 edges after acceptance for k misses.
  task automatic predict();
    exp_t e;
    int   c;
    int   k;
`ifndef CARD_SHOE_TEST_SEQ_EN
    logic [15:0] v;
    v = m_lfsr;
`endif
    c = 0;
    for (k = 0; k < 70000; k++) begin
`ifdef CARD_SHOE_TEST_SEQ_EN
      c     = seq_tbl[m_idx] - 1;
      m_idx = (m_idx + 1) % 16;
`else
      c = int'(v[3:0]);
      v = lfsr_step(v);
`endif
      if (c <= 12) if (m_cnt[c] > 0) break;
    end
    if (c <= 12) m_cnt[c]--;
    m_left--;
    e.rank = c + 1;
    e.lat  = k + 1;
    q.push_back(e);
  endtask

  // Entered and left #1 after a rising edge; leaves the card presented.
  task automatic get_card(input int hold, output int rank);
    exp_t e;
    int   n;
    if (m_left < int'(RA)) begin
      draw_req = 1'b1;
      @(posedge clk); #1;
      check_eq("auto_shuffling", shuffling, 1);
      check_eq("auto_ready_low", ready, 0);
      model_full();
      @(posedge clk); #1;
      check_eq("auto_shuffle_done", shuffling, 0);
      check_eq("auto_refill", cards_left, m_left);
    end
    check_eq("ready_idle", ready, 1);
    draw_req = 1'b1;
    @(posedge clk); #1;
    draw_req = 1'b0;
    predict();
    n = 0;
    while (card_valid !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    e = q.pop_front();
    check_eq("latency", n, e.lat);
    check_eq("rank", card_rank, e.rank);
    check_eq("value", card_value, (e.rank > 10) ? 10 : e.rank);
    check_eq("cards_left", cards_left, m_left);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", card_valid, 1);
      check_eq("hold_rank", card_rank, e.rank);
    end
    rank = int'(card_rank);
  endtask

  task automatic ack_card();
    card_ack = 1'b1;
    @(posedge clk); #1;
    card_ack = 1'b0;
    check_eq("ack_valid_low", card_valid, 0);
    check_eq("ack_rank_clr", card_rank, 0);
    check_eq("ack_value_clr", card_value, 0);
    check_eq("ack_ready", ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, r2, r;
    int tally [13];

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_valid", card_valid, 0);
    check_eq("rst_rank", card_rank, 0);
    check_eq("rst_value", card_value, 0);
    check_eq("rst_shuffling", shuffling, 0);
    check_eq("rst_left", cards_left, 52 * ND);
    model_full();
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Two draws from a fresh shoe.
    get_card(0, r1); ack_card();
    get_card(0, r2); ack_card();
    check_eq("left_after_two", cards_left, 52 * ND - 2);
`ifdef CARD_SHOE_TEST_SEQ_EN
    check_eq("seq_rank1", r1, 1);
    check_eq("seq_rank2", r2, 1);
`endif

    // Fifth card held without ack for 10 cycles.
    get_card(0, r); ack_card();
    get_card(0, r); ack_card();
    get_card(10, r);
`ifdef CARD_SHOE_TEST_SEQ_EN
    check_eq("seq_rank5", r, 13);
    check_eq("seq_value5", card_value, 10);
`endif
    ack_card();

    // Shuffle request while a card is presented is deferred until IDLE.
    get_card(0, r);
    shuffle = 1'b1;
    @(posedge clk); #1;
    shuffle = 1'b0;
    check_eq("pend_valid_held", card_valid, 1);
    check_eq("pend_left_unchanged", cards_left, m_left);
    check_eq("pend_no_shuffling", shuffling, 0);
    ack_card();
    @(posedge clk); #1;
    check_eq("pend_shuffling", shuffling, 1);
    check_eq("pend_ready_low", ready, 0);
    model_full();
    @(posedge clk); #1;
    check_eq("pend_shuffle_end", shuffling, 0);
    check_eq("pend_left_full", cards_left, 52 * ND);
    check_eq("pend_ready_back", ready, 1);

    // draw_req together with shuffle: shuffle wins, request dropped.
    draw_req = 1'b1;
    shuffle  = 1'b1;
    @(posedge clk); #1;
    draw_req = 1'b0;
    shuffle  = 1'b0;
    check_eq("both_shuffling", shuffling, 1);
    check_eq("both_no_valid", card_valid, 0);
    check_eq("both_ready_low", ready, 0);
    model_full();
    @(posedge clk); #1;
    check_eq("both_ready_back", ready, 1);
    check_eq("both_shuffle_end", shuffling, 0);
    check_eq("both_still_no_valid", card_valid, 0);
    check_eq("both_left_full", cards_left, 52 * ND);

    // Deal the whole shoe; every rank must appear exactly 4*ND times.
    for (int i = 0; i < 13; i++) tally[i] = 0;
    for (int d = 0; d < 52 * ND; d++) begin
      get_card(0, r);
      if (r >= 1 && r <= 13) tally[r-1]++;
      ack_card();
    end
    check_eq("empty_left", cards_left, 0);
    for (int i = 0; i < 13; i++) check_eq($sformatf("tally_rank%0d", i + 1), tally[i], 4 * ND);
    get_card(0, r);
    check_eq("refill_draw_left", cards_left, 52 * ND - 1);
    ack_card();

    // Asynchronous reset in the middle of a search.
    draw_req = 1'b1;
    @(posedge clk); #1;
    draw_req = 1'b0;
    check_eq("search_ready_low", ready, 0);
    #1 reset_n = 1'b0;
    #1;
    check_eq("async_ready", ready, 1);
    check_eq("async_valid", card_valid, 0);
    check_eq("async_rank", card_rank, 0);
    check_eq("async_value", card_value, 0);
    check_eq("async_shuffling", shuffling, 0);
    check_eq("async_left", cards_left, 52 * ND);
    model_full();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    get_card(0, r);
    ack_card();
    check_eq("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
